// File: rtl/pipelined_adder_pkg.sv
// Shared constants and elaboration helpers for the segmented pipelined add/subtract unit.
package pipelined_adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEG   = 8;

    function automatic int unsigned stages_f(input int unsigned width, input int unsigned seg);
        return (seg == 0) ? 32'd1 : width / seg;
    endfunction

    // Legal when the operand splits into a whole number of non-empty segments.
    function automatic bit cfg_ok_f(input int unsigned width, input int unsigned seg);
        return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/pipelined_seg_adder_if.sv
// Operand/result handshake bundle for pipelined_seg_adder.
interface pipelined_seg_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );

endinterface

// File: rtl/seg_adder.sv
// Combinational SEG-bit ripple adder from full-adder cells; also exposes the carry into its top bit.
module seg_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_seg_adder.sv
// Pipelined WIDTH-bit add/subtract: one SEG-bit carry segment per stage, carry registered between stages.
module pipelined_seg_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG   = DEF_SEG
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_seg_adder_if.slave io
);

    localparam int unsigned STAGES = stages_f(WIDTH, SEG);
    localparam int unsigned LAST   = STAGES - 1;

    if (!cfg_ok_f(WIDTH, SEG)) begin : g_cfg_check
        $error("pipelined_seg_adder: WIDTH must be a non-zero multiple of SEG");
    end

    logic             adv_c;

    // Rank k holds finished sum segments below k and raw A segments from k upward.
    logic             v_q [STAGES];
    logic             v_d [STAGES];
    logic [WIDTH-1:0] x_q [STAGES];
    logic [WIDTH-1:0] x_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];

    logic [SEG-1:0]   seg_sum_w [STAGES];
    logic             seg_co_w  [STAGES];
    logic             cm_top_w;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic cm_w;

        seg_adder #(.SEG(SEG)) u_seg (
            .a     (x_q[k][k*SEG +: SEG]),
            .b     (b_q[k][k*SEG +: SEG]),
            .cin   (c_q[k]),
            .sum   (seg_sum_w[k]),
            .cout  (seg_co_w[k]),
            .c_msb (cm_w)
        );

        // Only the top segment's internal carry feeds the overflow flag.
        if (k == LAST) begin : g_top
            assign cm_top_w = cm_w;
        end else begin : g_mid
            logic c_msb_unused;
            assign c_msb_unused = cm_w;
        end
    end

    always_comb begin
        adv_c = !out_valid_q || io.out_ready;

        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = v_q[k];
            x_d[k] = x_q[k];
            b_d[k] = b_q[k];
            c_d[k] = c_q[k];
        end
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        if (adv_c) begin
            v_d[0] = io.in_valid;
            x_d[0] = io.A;
            b_d[0] = io.Sub ? ~io.B : io.B;
            c_d[0] = io.Sub | io.Cin;

            for (int k = 1; k < STAGES; k++) begin
                v_d[k]                   = v_q[k-1];
                x_d[k]                   = x_q[k-1];
                x_d[k][(k-1)*SEG +: SEG] = seg_sum_w[k-1];
                b_d[k]                   = b_q[k-1];
                c_d[k]                   = seg_co_w[k-1];
            end

            // Result registers only reload on a valid beat so they hold across bubbles.
            out_valid_d = v_q[LAST];
            if (v_q[LAST]) begin
                sum_d                    = x_q[LAST];
                sum_d[LAST*SEG +: SEG]   = seg_sum_w[LAST];
                cout_d                   = seg_co_w[LAST];
                ovf_d                    = seg_co_w[LAST] ^ cm_top_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                x_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                x_q[k] <= x_d[k];
                b_q[k] <= b_d[k];
                c_q[k] <= c_d[k];
            end
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign io.in_ready  = adv_c;
    assign io.out_valid = out_valid_q;
    assign io.Sum       = sum_q;
    assign io.Cout      = cout_q;
    assign io.Ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_seg_adder.sv
// Scoreboard testbench for pipelined_seg_adder (WIDTH=32, SEG=8).
module tb_pipelined_seg_adder;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SEG    = 8;
    localparam int unsigned STAGES = WIDTH / SEG;
    localparam int          N_RAND = 10000;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   checks  = 0;
    int   errors  = 0;
    int   acc_cnt = 0;
    int   out_cnt = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    pipelined_seg_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_seg_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        logic [WIDTH-1:0] bp;
        logic [WIDTH:0]   full;
        logic             ci;
        exp_t             e;
        bp     = sub ? ~b : b;
        ci     = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, ci};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (a[WIDTH-1] == bp[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hold_out_valid: got %b want 0", bus.out_valid);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.Sum !== 32'h0) begin
            errors++; $display("FAIL reset_sum: got %h want 00000000", bus.Sum);
        end
        checks++;
        if (bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got Cout=%b Ovf=%b want 0 0", bus.Cout, bus.Ovf);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [4];
        logic [WIDTH-1:0] vb [4];
        logic             vc [4];
        logic             vs [4];
        logic [WIDTH-1:0] es [4];
        logic             eco [4];
        logic             eov [4];
        int               lat;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1; vc[0] = 1'b0; vs[0] = 1'b0;
        es[0] = 32'h0000_0000; eco[0] = 1'b1; eov[0] = 1'b0;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h1; vc[1] = 1'b0; vs[1] = 1'b0;
        es[1] = 32'h8000_0000; eco[1] = 1'b0; eov[1] = 1'b1;
        va[2] = 32'h5;         vb[2] = 32'h7; vc[2] = 1'b1; vs[2] = 1'b1;
        es[2] = 32'hFFFF_FFFE; eco[2] = 1'b0; eov[2] = 1'b0;
        va[3] = 32'h7;         vb[3] = 32'h5; vc[3] = 1'b1; vs[3] = 1'b1;
        es[3] = 32'h0000_0002; eco[3] = 1'b1; eov[3] = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.A = va[i]; bus.B = vb[i]; bus.Cin = vc[i]; bus.Sub = vs[i];
            bus.in_valid = 1'b1;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL directed_in_ready[%0d]: got %b want 1", i, bus.in_ready);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat = 0;
            for (int n = 1; n <= 10; n++) begin
                @(posedge clk); #1;
                if (bus.out_valid === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            checks++;
            if (lat != int'(STAGES)) begin
                errors++; $display("FAIL directed_latency[%0d]: got %0d cycles want %0d", i, lat, STAGES);
            end
            checks++;
            if (bus.Sum !== es[i] || bus.Cout !== eco[i] || bus.Ovf !== eov[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got Sum=%h Cout=%b Ovf=%b want Sum=%h Cout=%b Ovf=%b",
                         i, bus.Sum, bus.Cout, bus.Ovf, es[i], eco[i], eov[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int               base_acc;
        int               base_out;
        int               stall_left;
        logic             stalled_once;
        logic [WIDTH-1:0] snap_sum;
        logic             snap_cout;
        logic             snap_ovf;
        base_acc     = acc_cnt;
        base_out     = out_cnt;
        stall_left   = 0;
        stalled_once = 1'b0;
        snap_sum     = '0;
        snap_cout    = 1'b0;
        snap_ovf     = 1'b0;
        bus.Sub = 1'b0; bus.Cin = 1'b0; bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && (out_cnt - base_out) < 8; cyc++) begin
            if (acc_cnt - base_acc < 8) begin
                bus.in_valid = 1'b1;
                bus.A = WIDTH'(acc_cnt - base_acc + 1);
                bus.B = WIDTH'(acc_cnt - base_acc + 1);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (!stalled_once && bus.out_valid === 1'b1) begin
                stalled_once = 1'b1;
                stall_left   = 3;
                snap_sum     = bus.Sum;
                snap_cout    = bus.Cout;
                snap_ovf     = bus.Ovf;
                checks++;
                if (snap_sum !== 32'd2) begin
                    errors++; $display("FAIL bp_first_result: got %h want 00000002", snap_sum);
                end
            end
            bus.out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready: got %b want 0 during stall", bus.in_ready);
                end
                checks++;
                if (bus.out_valid !== 1'b1 || bus.Sum !== snap_sum || bus.Cout !== snap_cout || bus.Ovf !== snap_ovf) begin
                    errors++;
                    $display("FAIL bp_stable: got v=%b Sum=%h Cout=%b Ovf=%b want v=1 Sum=%h Cout=%b Ovf=%b",
                             bus.out_valid, bus.Sum, bus.Cout, bus.Ovf, snap_sum, snap_cout, snap_ovf);
                end
                stall_left--;
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (stalled_once !== 1'b1) begin
            errors++; $display("FAIL bp_no_output: got no result before timeout want stall to occur");
        end
        checks++;
        if (out_cnt - base_out != 8 || acc_cnt - base_acc != 8) begin
            errors++; $display("FAIL bp_counts: got in=%0d out=%0d want 8 8", acc_cnt - base_acc, out_cnt - base_out);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL bp_outstanding: got %0d beats left want 0", sb_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        bus.out_ready = 1'b1; bus.Sub = 1'b0; bus.Cin = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus.in_valid = 1'b1;
            bus.A = WIDTH'(32'h100 + j);
            bus.B = WIDTH'(32'h10);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL midflight_pre: got out_valid=%b want 1", bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midflight_async: got out_valid=%b want 0", bus.out_valid);
        end
        sb_q.delete();
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL midflight_stale[%0d]: got out_valid=%b want 0", n, bus.out_valid);
            end
        end
        bus.A = 32'h1234_5678; bus.B = 32'h1111_1111; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != int'(STAGES) || bus.Sum !== 32'h2345_6789) begin
            errors++; $display("FAIL midflight_after: got lat=%0d Sum=%h want lat=%0d Sum=23456789", lat, bus.Sum, STAGES);
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0;
            default: return WIDTH'($urandom());
        endcase
    endfunction

    task automatic test_random();
        int base_acc;
        base_acc = acc_cnt;
        for (int cyc = 0; cyc < 60000 && (acc_cnt - base_acc) < N_RAND; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.A         = pick_operand();
            bus.B         = pick_operand();
            bus.Cin       = 1'($urandom_range(0, 1));
            bus.Sub       = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && sb_q.size() != 0; cyc++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checks++;
        if (acc_cnt - base_acc != N_RAND) begin
            errors++; $display("FAIL random_count: got %0d beats accepted want %0d", acc_cnt - base_acc, N_RAND);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL random_drain: got %0d beats outstanding want 0", sb_q.size());
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        bus.Sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Scoreboard monitor: inputs are stable at the falling edge, so handshakes seen here complete at the next rise.
        fork
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1) begin
                    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                        checks++;
                        out_cnt++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL scoreboard_extra: got Sum=%h Cout=%b Ovf=%b want no output",
                                     bus.Sum, bus.Cout, bus.Ovf);
                        end else begin
                            mon_e = sb_q.pop_front();
                            if (bus.Sum !== mon_e.sum || bus.Cout !== mon_e.cout || bus.Ovf !== mon_e.ovf) begin
                                errors++;
                                $display("FAIL scoreboard: got Sum=%h Cout=%b Ovf=%b want Sum=%h Cout=%b Ovf=%b",
                                         bus.Sum, bus.Cout, bus.Ovf, mon_e.sum, mon_e.cout, mon_e.ovf);
                            end
                        end
                    end
                    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                        sb_q.push_back(model(bus.A, bus.B, bus.Cin, bus.Sub));
                        acc_cnt++;
                    end
                end
            end
        join_none

        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
